// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl: stall/flush sequencer for the 7-stage OoO pipe (optional deadlock watchdog under DEADLOCK_WDOG_EN)
module pipeline_hazard_ctrl #(
    parameter int INIT_CYCLES    = 4,
    parameter int RECOVER_CYCLES = 2,
    parameter int WDOG_LIMIT     = 1024
) (
    input  logic       i_clk,
    input  logic       i_resetn,
    input  logic       i_branch_miss,
    input  logic       i_iq_full,
    input  logic       i_rob_full,
    output logic [6:0] o_stall,
    output logic [5:0] o_flush,
`ifdef DEADLOCK_WDOG_EN
    output logic       o_wdog_err,
`endif
    output logic       o_busy
);
    localparam int MAXC = INIT_CYCLES > RECOVER_CYCLES ? INIT_CYCLES : RECOVER_CYCLES;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] INIT_LD = CW'(INIT_CYCLES - 1);
    localparam logic [CW-1:0] REC_LD = CW'(RECOVER_CYCLES > 0 ? RECOVER_CYCLES - 1 : 0);
    typedef enum logic [1:0] {S_INIT, S_RUN, S_RECOVER} state_t;
    state_t r_state, w_state_nxt;
    logic [CW-1:0] r_cnt, w_cnt_nxt;
    logic w_bp;
    assign w_bp = i_iq_full | i_rob_full;
    // state and sequence counter
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_state <= S_INIT;
            r_cnt   <= INIT_LD;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end
    // next state: INIT and RECOVER count down to RUN; a miss (re)starts recovery
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_INIT: begin
                w_state_nxt = r_cnt == '0 ? S_RUN : S_INIT;
                w_cnt_nxt   = r_cnt == '0 ? '0 : r_cnt - 1'b1;
            end
            S_RUN: begin
                if (i_branch_miss && RECOVER_CYCLES > 0) begin
                    w_state_nxt = S_RECOVER;
                    w_cnt_nxt   = REC_LD;
                end
            end
            S_RECOVER: begin
                if (i_branch_miss) w_cnt_nxt = REC_LD;
                else if (r_cnt == '0) w_state_nxt = S_RUN;
                else w_cnt_nxt = r_cnt - 1'b1;
            end
            default: begin
                w_state_nxt = S_INIT;
                w_cnt_nxt   = INIT_LD;
            end
        endcase
    end
    // outputs: miss beats backpressure; rename is idle during recovery so backpressure is ignored there
    always_comb begin
        o_stall = 7'h00;
        o_flush = 6'h00;
        case (r_state)
            S_RUN: begin
                o_stall = i_branch_miss ? 7'h00 : w_bp ? 7'h07 : 7'h00;
                o_flush = i_branch_miss ? 6'h3F : w_bp ? 6'h04 : 6'h00;
            end
            S_RECOVER: begin
                o_stall = i_branch_miss ? 7'h00 : 7'h03;
                o_flush = i_branch_miss ? 6'h3F : 6'h02;
            end
            default: begin
                o_stall = 7'h01;
                o_flush = 6'h3F;
            end
        endcase
    end
    assign o_busy = r_state != S_RUN;
`ifdef DEADLOCK_WDOG_EN
    localparam logic [10:0] WLIM = 11'(WDOG_LIMIT);
    logic [10:0] r_wdog_cnt, w_wdog_nxt;
    logic r_wdog_err;
    // saturating count of consecutive fetch stalls; INIT cycles freeze it
    always_comb begin
        w_wdog_nxt = r_state == S_INIT ? r_wdog_cnt :
                     !o_stall[0] ? 11'd0 :
                     &r_wdog_cnt ? r_wdog_cnt : r_wdog_cnt + 11'd1;
    end
    // sticky error once the stall run reaches the limit
    always_ff @(posedge i_clk or negedge i_resetn) begin
        if (!i_resetn) begin
            r_wdog_cnt <= '0;
            r_wdog_err <= 1'b0;
        end else begin
            r_wdog_cnt <= w_wdog_nxt;
            r_wdog_err <= r_wdog_err | (w_wdog_nxt >= WLIM);
        end
    end
    assign o_wdog_err = r_wdog_err;
`endif
endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb_pipeline_hazard_ctrl: scoreboard bench for pipeline_hazard_ctrl
module tb_pipeline_hazard_ctrl;
    logic clk, resetn, branch_miss, iq_full, rob_full;
    logic [6:0] stall;
    logic [5:0] flush;
    logic busy, wd;
    int n_assert = 0;
    int n_fail = 0;
    logic exp_wd = 1'b0;
    typedef struct {string tag; logic [14:0] exp;} sb_t;
    sb_t sbq[$];
`ifdef DEADLOCK_WDOG_EN
    logic wdog_err;
    assign wd = wdog_err;
`else
    assign wd = 1'b0;
`endif
    pipeline_hazard_ctrl #(.INIT_CYCLES(4), .RECOVER_CYCLES(2), .WDOG_LIMIT(16)) dut (
        .i_clk(clk), .i_resetn(resetn), .i_branch_miss(branch_miss),
        .i_iq_full(iq_full), .i_rob_full(rob_full),
        .o_stall(stall), .o_flush(flush),
`ifdef DEADLOCK_WDOG_EN
        .o_wdog_err(wdog_err),
`endif
        .o_busy(busy)
    );
    initial clk = 1'b0;
    always #5 clk = ~clk;
    task automatic check_eq(input string tag, input logic [14:0] obs, input logic [14:0] exp);
        n_assert++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got {wd,busy,stall,flush}=%h expected %h", tag, obs, exp);
        end
    endtask
    // one cycle of stimulus; the expected outputs for that cycle go on the scoreboard
    task automatic cyc(input string tag, input logic rn, input logic bm, input logic iq, input logic rob,
                       input logic [6:0] es, input logic [5:0] ef, input logic eb);
        sb_t e;
        @(posedge clk);
        #1;
        resetn = rn;
        branch_miss = bm;
        iq_full = iq;
        rob_full = rob;
        e.tag = tag;
        e.exp = {exp_wd, eb, es, ef};
        sbq.push_back(e);
    endtask
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            sb_t e;
            e = sbq.pop_front();
            check_eq(e.tag, {wd, busy, stall, flush}, e.exp);
        end
    end
    initial begin
        resetn = 1'b0;
        branch_miss = 1'b0;
        iq_full = 1'b0;
        rob_full = 1'b0;
        cyc("rst_hold", 0, 0, 1, 1, 7'h01, 6'h3F, 1);
        cyc("rst_hold_miss", 0, 1, 0, 0, 7'h01, 6'h3F, 1);
        for (int i = 0; i < 4; i++) cyc("init", 1, i == 1, i == 2, 0, 7'h01, 6'h3F, 1);
        cyc("init_done", 1, 0, 0, 0, 7'h00, 6'h00, 0);
        cyc("idle", 1, 0, 0, 0, 7'h00, 6'h00, 0);
        cyc("miss", 1, 1, 0, 0, 7'h00, 6'h3F, 0);
        cyc("rec1", 1, 0, 0, 0, 7'h03, 6'h02, 1);
        cyc("rec2", 1, 0, 0, 0, 7'h03, 6'h02, 1);
        cyc("rec_done", 1, 0, 0, 0, 7'h00, 6'h00, 0);
        for (int i = 0; i < 5; i++) cyc("bp_iq", 1, 0, 1, 0, 7'h07, 6'h04, 0);
        for (int i = 0; i < 3; i++) cyc("bp_rob", 1, 0, 0, 1, 7'h07, 6'h04, 0);
        cyc("bp_release", 1, 0, 0, 0, 7'h00, 6'h00, 0);
        cyc("miss_vs_iq", 1, 1, 1, 0, 7'h00, 6'h3F, 0);
        cyc("rec_ign_iq1", 1, 0, 1, 1, 7'h03, 6'h02, 1);
        cyc("rec_ign_iq2", 1, 0, 1, 0, 7'h03, 6'h02, 1);
        cyc("bp_after_rec", 1, 0, 1, 0, 7'h07, 6'h04, 0);
        cyc("idle2", 1, 0, 0, 0, 7'h00, 6'h00, 0);
        cyc("miss2", 1, 1, 0, 0, 7'h00, 6'h3F, 0);
        cyc("rec_a", 1, 0, 0, 0, 7'h03, 6'h02, 1);
        cyc("miss_in_rec", 1, 1, 0, 0, 7'h00, 6'h3F, 1);
        cyc("rec_restart1", 1, 0, 0, 0, 7'h03, 6'h02, 1);
        cyc("rec_restart2", 1, 0, 0, 0, 7'h03, 6'h02, 1);
        cyc("idle3", 1, 0, 0, 0, 7'h00, 6'h00, 0);
        for (int i = 0; i < 15; i++) cyc("wd_15", 1, 0, 0, 1, 7'h07, 6'h04, 0);
        cyc("wd_15_rel", 1, 0, 0, 0, 7'h00, 6'h00, 0);
        for (int i = 0; i < 16; i++) cyc("wd_16", 1, 0, 0, 1, 7'h07, 6'h04, 0);
`ifdef DEADLOCK_WDOG_EN
        exp_wd = 1'b1;
`endif
        cyc("wd_16_rel", 1, 0, 0, 0, 7'h00, 6'h00, 0);
        cyc("wd_sticky", 1, 0, 0, 0, 7'h00, 6'h00, 0);
        cyc("miss3", 1, 1, 0, 0, 7'h00, 6'h3F, 0);
        cyc("rec_b", 1, 0, 0, 0, 7'h03, 6'h02, 1);
        exp_wd = 1'b0;
        cyc("rst_mid_rec", 0, 0, 0, 0, 7'h01, 6'h3F, 1);
        for (int i = 0; i < 4; i++) cyc("reinit", 1, 0, 0, 0, 7'h01, 6'h3F, 1);
        cyc("reinit_done", 1, 0, 0, 0, 7'h00, 6'h00, 0);
        cyc("bp_pre_rst", 1, 0, 0, 1, 7'h07, 6'h04, 0);
        cyc("rst_mid_bp", 0, 0, 0, 1, 7'h01, 6'h3F, 1);
        for (int i = 0; i < 4; i++) cyc("reinit_bp", 1, 0, 0, 1, 7'h01, 6'h3F, 1);
        cyc("run_bp", 1, 0, 0, 1, 7'h07, 6'h04, 0);
        cyc("run_idle", 1, 0, 0, 0, 7'h00, 6'h00, 0);
        @(negedge clk);
        #1;
        if (sbq.size() != 0) check_eq("drain", 15'(sbq.size()), 15'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
